// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Single-outstanding instruction fetch engine. Presents a word-aligned
// address to instruction memory, waits (bounded by MAX_WAIT_CYCLES) for the
// acknowledge, then holds the fetched word for decode until it is accepted.
// Misaligned program counters and memory timeouts park the unit in a sticky
// error state that only flush or reset clears.
//
// Optional feature: define FETCH_COUNTER_EN to add the 32-bit fetchCount
// output, which counts instructions handed to decode.
module instruction_fetch_unit #(
    parameter int unsigned MAX_WAIT_CYCLES = 255  // legal range 1..65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pcIn,
    input  logic        flush,
    output logic [31:0] memAddress,
    output logic        memRequest,
    input  logic        memAck,
    input  logic [31:0] memData,
    output logic [31:0] instruction,
    output logic [31:0] instructionPC,
    output logic        instructionValid,
    input  logic        instructionReady,
    output logic        fetchMisaligned,
    output logic        fetchTimeout
`ifdef FETCH_COUNTER_EN
    ,
    output logic [31:0] fetchCount
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        VALID   = 2'd2,
        ERROR   = 2'd3
    } state_t;

    // The wait counter only ever reaches MAX_WAIT_CYCLES-1, so 16 bits cover
    // the whole legal range; the incremented value is compared at 17 bits.
    localparam logic [16:0] WAIT_LIMIT = 17'(MAX_WAIT_CYCLES);

    state_t      state_q,       state_d;
    logic [31:0] addr_q,        addr_d;
    logic [31:0] instr_q,       instr_d;
    logic [31:0] instr_pc_q,    instr_pc_d;
    logic        misaligned_q,  misaligned_d;
    logic        timeout_q,     timeout_d;
    logic [15:0] wait_cnt_q,    wait_cnt_d;
    logic [16:0] wait_cnt_inc;
`ifdef FETCH_COUNTER_EN
    logic [31:0] fetch_count_q, fetch_count_d;
`endif

    assign wait_cnt_inc = {1'b0, wait_cnt_q} + 17'd1;

    // Next-state and datapath update; flush dominates every other input.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        misaligned_d = misaligned_q;
        timeout_d    = timeout_q;
        wait_cnt_d   = wait_cnt_q;
`ifdef FETCH_COUNTER_EN
        fetch_count_d = fetch_count_q;
`endif
        if (flush) begin
            state_d      = IDLE;
            misaligned_d = 1'b0;
            timeout_d    = 1'b0;
            wait_cnt_d   = 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pcIn[1:0] == 2'b00) begin
                        addr_d     = pcIn;
                        wait_cnt_d = 16'd0;
                        state_d    = REQUEST;
                    end else begin
                        misaligned_d = 1'b1;
                        state_d      = ERROR;
                    end
                end
                REQUEST: begin
                    // An acknowledge in the timeout cycle still completes the fetch.
                    if (memAck) begin
                        instr_d    = memData;
                        instr_pc_d = addr_q;
                        state_d    = VALID;
                    end else if (wait_cnt_inc == WAIT_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_inc[15:0];
                    end
                end
                VALID: begin
                    if (instructionReady) begin
                        state_d = IDLE;
`ifdef FETCH_COUNTER_EN
                        fetch_count_d = fetch_count_q + 32'd1;
`endif
                    end
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: every register here, data included, is reset so the outputs
        // read as zero the moment reset asserts, not one edge later.
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= 32'd0;
            instr_q      <= 32'd0;
            instr_pc_q   <= 32'd0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            wait_cnt_q   <= 16'd0;
`ifdef FETCH_COUNTER_EN
            fetch_count_q <= 32'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            addr_q       <= addr_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
            wait_cnt_q   <= wait_cnt_d;
`ifdef FETCH_COUNTER_EN
            fetch_count_q <= fetch_count_d;
`endif
        end
    end

    // Every output is decoded directly from registered state.
    assign memRequest       = (state_q == REQUEST);
    assign instructionValid = (state_q == VALID);
    assign memAddress       = addr_q;
    assign instruction      = instr_q;
    assign instructionPC    = instr_pc_q;
    assign fetchMisaligned  = misaligned_q;
    assign fetchTimeout     = timeout_q;
`ifdef FETCH_COUNTER_EN
    assign fetchCount       = fetch_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit (MAX_WAIT_CYCLES = 4).
// Directed vector table, hand-written corner sequences, then a randomized
// run against a transaction-level reference model.
// Define FETCH_COUNTER_EN to also exercise the fetchCount output.
module tb_instruction_fetch_unit;

    localparam int MAX_WAIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pcIn;
    logic        flush;
    logic [31:0] memAddress;
    logic        memRequest;
    logic        memAck;
    logic [31:0] memData;
    logic [31:0] instruction;
    logic [31:0] instructionPC;
    logic        instructionValid;
    logic        instructionReady;
    logic        fetchMisaligned;
    logic        fetchTimeout;
`ifdef FETCH_COUNTER_EN
    logic [31:0] fetchCount;
`endif

    instruction_fetch_unit #(.MAX_WAIT_CYCLES(MAX_WAIT)) dut (
        .clock            (clock),
        .reset            (reset),
        .pcIn             (pcIn),
        .flush            (flush),
        .memAddress       (memAddress),
        .memRequest       (memRequest),
        .memAck           (memAck),
        .memData          (memData),
        .instruction      (instruction),
        .instructionPC    (instructionPC),
        .instructionValid (instructionValid),
        .instructionReady (instructionReady),
        .fetchMisaligned  (fetchMisaligned),
        .fetchTimeout     (fetchTimeout)
`ifdef FETCH_COUNTER_EN
        ,
        .fetchCount       (fetchCount)
`endif
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] pc;
        logic        fl;
        logic        ack;
        logic [31:0] data;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_mis;
        logic        e_to;
    } vec_t;

    vec_t tbl [9];

    // Reference model: one outstanding fetch, described as flags plus a
    // count of unanswered request cycles.
    bit          m_req, m_valid, m_mis, m_to;
    int          m_wait;
    logic [31:0] m_addr, m_instr, m_ipc;
`ifdef FETCH_COUNTER_EN
    logic [31:0] m_count;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctl_act();
        return {28'd0, memRequest, instructionValid, fetchMisaligned, fetchTimeout};
    endfunction

    function automatic logic [31:0] ctl_exp(input logic req, input logic vld, input logic mis, input logic to);
        return {28'd0, req, vld, mis, to};
    endfunction

    task automatic check_outputs(input string tag, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_valid, input logic [31:0] e_instr,
                                 input logic [31:0] e_ipc, input logic e_mis, input logic e_to);
        check({tag, "_ctl"},   ctl_act(),     ctl_exp(e_req, e_valid, e_mis, e_to));
        check({tag, "_addr"},  memAddress,    e_addr);
        check({tag, "_instr"}, instruction,   e_instr);
        check({tag, "_ipc"},   instructionPC, e_ipc);
    endtask

    task automatic drive(input logic [31:0] pc, input logic fl, input logic ack,
                         input logic [31:0] data, input logic rdy);
        pcIn             = pc;
        flush            = fl;
        memAck           = ack;
        memData          = data;
        instructionReady = rdy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        m_req = 0; m_valid = 0; m_mis = 0; m_to = 0; m_wait = 0;
        m_addr = 0; m_instr = 0; m_ipc = 0;
`ifdef FETCH_COUNTER_EN
        m_count = 0;
`endif
    endtask

    task automatic model_step(input logic [31:0] pc, input logic fl, input logic ack,
                              input logic [31:0] data, input logic rdy);
        if (fl) begin
            m_req = 0; m_valid = 0; m_mis = 0; m_to = 0;
        end else if (m_req) begin
            if (ack) begin
                m_instr = data; m_ipc = m_addr; m_req = 0; m_valid = 1;
            end else begin
                m_wait++;
                if (m_wait == MAX_WAIT) begin
                    m_req = 0; m_to = 1;
                end
            end
        end else if (m_valid) begin
            if (rdy) begin
                m_valid = 0;
`ifdef FETCH_COUNTER_EN
                m_count = m_count + 32'd1;
`endif
            end
        end else if (!(m_mis || m_to)) begin
            if (pc[1:0] == 2'b00) begin
                m_addr = pc; m_req = 1; m_wait = 0;
            end else begin
                m_mis = 1;
            end
        end
    endtask

    initial begin
        logic [31:0] r_pc, r_data, r_sel;
        logic        r_fl, r_ack, r_rdy;

        // pc, flush, ack, data, ready | req, addr, valid, instr, ipc, mis, to
        tbl[0] = '{32'h100, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h100, 1'b0, 32'h0,        32'h0,   1'b0, 1'b0};
        tbl[1] = '{32'h200, 1'b0, 1'b1, 32'h13,       1'b0, 1'b0, 32'h100, 1'b1, 32'h13,       32'h100, 1'b0, 1'b0};
        tbl[2] = '{32'h200, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h100, 1'b0, 32'h13,       32'h100, 1'b0, 1'b0};
        tbl[3] = '{32'h102, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h100, 1'b0, 32'h13,       32'h100, 1'b1, 1'b0};
        tbl[4] = '{32'h104, 1'b0, 1'b1, 32'h77,       1'b1, 1'b0, 32'h100, 1'b0, 32'h13,       32'h100, 1'b1, 1'b0};
        tbl[5] = '{32'h104, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h100, 1'b0, 32'h13,       32'h100, 1'b0, 1'b0};
        tbl[6] = '{32'h104, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h104, 1'b0, 32'h13,       32'h100, 1'b0, 1'b0};
        tbl[7] = '{32'h108, 1'b0, 1'b1, 32'h00500093, 1'b0, 1'b0, 32'h104, 1'b1, 32'h00500093, 32'h104, 1'b0, 1'b0};
        tbl[8] = '{32'h108, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h104, 1'b0, 32'h00500093, 32'h104, 1'b0, 1'b0};

        // Reset values appear as soon as reset asserts.
        reset = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check_outputs("reset_hold", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_COUNTER_EN
        check("reset_count", fetchCount, 32'd0);
`endif
        reset = 1'b0;

        // Basic fetch, misaligned error, flush recovery, second fetch.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].pc, tbl[i].fl, tbl[i].ack, tbl[i].data, tbl[i].rdy);
            tick();
            check_outputs($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
                          tbl[i].e_instr, tbl[i].e_ipc, tbl[i].e_mis, tbl[i].e_to);
        end
`ifdef FETCH_COUNTER_EN
        check("table_count", fetchCount, 32'd2);
`endif

        // Decode stalls for 5 cycles while memory keeps toggling.
        drive(32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        drive(32'h300, 1'b0, 1'b1, 32'hAAAA5555, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(32'h1000 + 32'(i * 4), 1'b0, 1'b1, $urandom(), 1'b0);
            tick();
            check($sformatf("stall%0d_ctl", i),   ctl_act(),     ctl_exp(1'b0, 1'b1, 1'b0, 1'b0));
            check($sformatf("stall%0d_instr", i), instruction,   32'hAAAA5555);
            check($sformatf("stall%0d_ipc", i),   instructionPC, 32'h300);
        end
        drive(32'h400, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        check("stall_release_ctl", ctl_act(), ctl_exp(1'b0, 1'b0, 1'b0, 1'b0));
`ifdef FETCH_COUNTER_EN
        check("stall_release_count", fetchCount, 32'd3);
`endif

        // Timeout after MAX_WAIT unanswered request cycles.
        drive(32'h400, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check("to_req1_ctl", ctl_act(), ctl_exp(1'b1, 1'b0, 1'b0, 1'b0));
        check("to_req1_addr", memAddress, 32'h400);
        for (int k = 2; k <= MAX_WAIT; k++) begin
            tick();
            check($sformatf("to_req%0d_ctl", k), ctl_act(), ctl_exp(1'b1, 1'b0, 1'b0, 1'b0));
        end
        tick();
        check("to_fire_ctl", ctl_act(), ctl_exp(1'b0, 1'b0, 1'b0, 1'b1));
        tick();
        check("to_sticky_ctl", ctl_act(), ctl_exp(1'b0, 1'b0, 1'b0, 1'b1));
        drive(32'h404, 1'b1, 1'b0, 32'h0, 1'b0);
        tick();
        check("to_flush_ctl", ctl_act(), ctl_exp(1'b0, 1'b0, 1'b0, 1'b0));

        // Acknowledge in the last allowed cycle wins over the timeout.
        drive(32'h404, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        for (int k = 2; k <= MAX_WAIT; k++) tick();
        check("late_ack_wait_ctl", ctl_act(), ctl_exp(1'b1, 1'b0, 1'b0, 1'b0));
        drive(32'h404, 1'b0, 1'b1, 32'h0000CAFE, 1'b0);
        tick();
        check_outputs("late_ack", 1'b0, 32'h404, 1'b1, 32'h0000CAFE, 32'h404, 1'b0, 1'b0);
        drive(32'h500, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        check("late_ack_done_ctl", ctl_act(), ctl_exp(1'b0, 1'b0, 1'b0, 1'b0));

        // Flush while holding a valid instruction beats ready.
        drive(32'h500, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        drive(32'h500, 1'b0, 1'b1, 32'h00001111, 1'b0);
        tick();
        drive(32'h500, 1'b1, 1'b0, 32'h0, 1'b1);
        tick();
        check("flush_valid_ctl", ctl_act(), ctl_exp(1'b0, 1'b0, 1'b0, 1'b0));
`ifdef FETCH_COUNTER_EN
        check("flush_valid_count", fetchCount, 32'd4);
`endif

        // Flush with acknowledge in the same cycle beats the acknowledge.
        drive(32'h504, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check("flush_ack_pre_ctl", ctl_act(), ctl_exp(1'b1, 1'b0, 1'b0, 1'b0));
        drive(32'h504, 1'b1, 1'b1, 32'h00002222, 1'b1);
        tick();
        check("flush_ack_ctl", ctl_act(), ctl_exp(1'b0, 1'b0, 1'b0, 1'b0));
        check("flush_ack_instr", instruction, 32'h00001111);

        // Asynchronous reset in the middle of a request.
        drive(32'h508, 1'b0, 1'b1, 32'h00003333, 1'b0);
        tick();
        check("rst_mid_pre_ctl", ctl_act(), ctl_exp(1'b1, 1'b0, 1'b0, 1'b0));
        #2;
        reset = 1'b1;
        #1;
        check_outputs("rst_mid", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
`ifdef FETCH_COUNTER_EN
        check("rst_mid_count", fetchCount, 32'd0);
`endif
        tick();
        check_outputs("rst_mid_hold", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        drive(32'h600, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        check("rst_release_ctl", ctl_act(), ctl_exp(1'b1, 1'b0, 1'b0, 1'b0));
        check("rst_release_addr", memAddress, 32'h600);

`ifdef FETCH_COUNTER_EN
        // Counter wraps from all-ones to zero on a handshake.
        drive(32'h600, 1'b0, 1'b1, 32'h00004444, 1'b0);
        tick();
        dut.fetch_count_q = 32'hFFFF_FFFF;
        drive(32'h600, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        check("wrap_count", fetchCount, 32'd0);
`endif

        // Randomized run against the reference model, from a clean reset.
        reset = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        model_reset();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 600; c++) begin
            r_pc  = $urandom();
            r_sel = $urandom_range(0, 7);
            r_pc[1:0] = (r_sel == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            r_fl  = ($urandom_range(0, 19) == 0);
            r_ack = ($urandom_range(0, 2) == 0);
            r_rdy = ($urandom_range(0, 1) == 0);
            r_data = $urandom();
            drive(r_pc, r_fl, r_ack, r_data, r_rdy);
            model_step(r_pc, r_fl, r_ack, r_data, r_rdy);
            tick();
            check_outputs($sformatf("rand%0d", c), m_req, m_addr, m_valid, m_instr, m_ipc, m_mis, m_to);
`ifdef FETCH_COUNTER_EN
            check($sformatf("rand%0d_count", c), fetchCount, m_count);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
